uart_var_limit_rx: RTL and testbench
====================================

// Module: uart_var_limit_rx
// PURPOSE
//  UART receiver with a runtime-programmable bit period, the receive side of the variable-limit UART link.
//  Oversamples rx with clk, detects and validates the start bit and samples every bit at mid-period.
//  Delivers one byte per frame with a 1-cycle valid strobe, plus frame- and parity-error strobes.
// PARAMETERS
//  DIV_W     16  width of baud_div (clk cycles per bit)
//  PARITY    0   0 = no parity bit, 1 = even parity, 2 = odd parity
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  baud_div    in   DIV_W  clk cycles per UART bit; values < 4 are treated as 4
//  rx          in   1      serial input, asynchronous to clk, idle high
//  rx_data     out  8      last received byte, LSB first on the line
//  rx_valid    out  1      1-cycle pulse: rx_data updated with a good frame
//  frame_err   out  1      1-cycle pulse: stop bit sampled low
//  parity_err  out  1      1-cycle pulse: parity mismatch (PARITY != 0 only)
//  busy        out  1      high from start-bit detection until return to IDLE
// BEHAVIOUR
//  Reset: rx_data = 8'h00; rx_valid, frame_err, parity_err, busy = 0; state = IDLE.
//  Synchroniser flops reset to 1; all sampling uses the synchronised rx_s.
//  Reset mid-frame aborts it: no strobes are issued and the partial byte is discarded.
//  Clock-cycle divisor: div = max(baud_div, 4), latched into div_q on the IDLE->START transition.
//  Changing baud_div mid-frame has no effect until the next frame.
//  Bit counter: counts 0..div_q-1 and wraps, same wrap rule as the TX counter.
//  Half period: half = div_q >> 1.
//  FSM states:
//   IDLE: on rx_s == 0, go to START with cnt = 0 and busy = 1.
//   START: on cnt == half-1, sample rx_s.
//    - rx_s == 0: go to DATA with cnt = 0 and bit_idx = 0.
//    - rx_s == 1: false start; go to IDLE with no strobe.
//   DATA: on cnt == div_q-1, shift rx_s into sh[bit_idx] (LSB first).
//    - After bit_idx == 7, go to PARITY if PARITY != 0, else to STOP.
//   PARITY: on cnt == div_q-1, compare rx_s with the expected parity.
//    - Even: expected = ^sh. Odd: expected = ~^sh.
//    - Store the mismatch flag; go to STOP.
//   STOP: on cnt == div_q-1, sample rx_s.
//    - rx_s == 1 and no parity mismatch: rx_data <= sh, rx_valid = 1 for one cycle; go to IDLE.
//    - rx_s == 1 and parity mismatch: parity_err = 1 for one cycle, rx_data unchanged; go to IDLE.
//    - rx_s == 0: frame_err = 1 for one cycle, rx_data unchanged; go to WAIT_HI.
//      frame_err takes priority over parity_err; only one strobe per frame.
//   WAIT_HI: stay until rx_s == 1, then go to IDLE. A break does not retrigger reception.
//  busy clears in the same cycle the FSM enters IDLE.
//  Latency: strobe at 2 (sync) + half + (8 + P + 1) * div_q clk cycles after the rx falling edge, ±1 cycle.
//   P = 1 if PARITY != 0, else 0.
//  Back-to-back frames: the next start bit is accepted the cycle after return to IDLE; no idle gap is needed.
//  Strobe outputs are registered and never asserted together.
// TESTING
//  T1: PARITY=0, baud_div=16, send 0xA5 with 1 stop bit -> exactly one rx_valid pulse, rx_data=8'hA5, no error strobes.
//  T2: baud_div=16, rx low for 3 cycles then high -> no strobe; busy high for fewer than 10 cycles, then IDLE.
//  T3: baud_div=10, send 0x3C with stop bit = 0, then hold rx low 40 cycles -> one frame_err pulse;
//      rx_data keeps its previous value; busy stays high until rx returns high; no second frame.
//  T4: PARITY=1, baud_div=8, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid;
//      then send 0x07 with parity bit 1 -> rx_valid with rx_data=8'h07.
//  T5: baud_div changes 16->32 during bit 3 of a 0x5A frame -> 0x5A still received at 16;
//      the next frame received correctly at 32. baud_div=2 is received correctly as div 4.
//  T6: assert rst during bit 5 of a frame, release, then send 0x81 -> no strobe for the aborted frame;
//      outputs read 0 during reset; rx_valid with rx_data=8'h81 afterwards.

Source files
------------

// File: rtl/uart_var_limit_rx.sv
// UART receiver with a runtime-programmable bit period.
// rx is double-flopped, the start bit is checked at mid-period and
// every data/parity/stop bit is sampled one full period after that.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low
// START   | confirming the start bit at half a bit period
// DATA    | shifting in 8 data bits, LSB first
// PARITY  | checking the parity bit (only when PARITY != 0)
// STOP    | sampling the stop bit, issuing the result strobe
// WAIT_HI | line held low after a framing error, waiting for idle
module uart_var_limit_rx #(
  parameter int DIV_W  = 16,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
  } state_t;

  state_t           state_q, state_d;
  logic             rx_m_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             perr_q, perr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             busy_q, busy_d;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] half_m1;
  logic             tick;
  logic             exp_par;

  assign div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
  assign half_m1 = (div_q >> 1) - DIV_W'(1);
  assign tick    = (cnt_q == div_q - DIV_W'(1));
  // Odd parity expects the complement of the data XOR.
  assign exp_par = (PARITY == 2) ? ~^sh_q : ^sh_q;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      sh_q         <= sh_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, bit counter, shift register and result strobes.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = tick ? '0 : cnt_q + DIV_W'(1);
    bit_idx_d    = bit_idx_q;
    sh_d         = sh_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          div_d   = div_eff;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d[bit_idx_q] = rx_s_q;
          bit_idx_d       = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          perr_d  = (rx_s_q != exp_par);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HI;
          end else if (perr_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_WAIT_HI: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_var_limit_rx.sv
// Bench for uart_var_limit_rx: three receivers (no, even, odd parity),
// each on its own rx line; frames are driven bit by bit and the result
// strobes are compared against a frame-level outcome model.
module tb_uart_var_limit_rx;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx0, rx1, rx2;
  logic [7:0]  rxd [3];
  logic        vld [3];
  logic        fe  [3];
  logic        pe  [3];
  logic        bsy [3];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int vcnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};
  int pcnt [3] = '{0, 0, 0};
  int bcnt [3] = '{0, 0, 0};
  int multi [3] = '{0, 0, 0};
  int vcyc [3] = '{0, 0, 0};
  logic [7:0] last_good [3];
  int fall_cyc;
  int sv, sf, sp, sb;

  uart_var_limit_rx #(.DIV_W(16), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx0), .rx_data(rxd[0]),
    .rx_valid(vld[0]), .frame_err(fe[0]), .parity_err(pe[0]), .busy(bsy[0]));
  uart_var_limit_rx #(.DIV_W(16), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx1), .rx_data(rxd[1]),
    .rx_valid(vld[1]), .frame_err(fe[1]), .parity_err(pe[1]), .busy(bsy[1]));
  uart_var_limit_rx #(.DIV_W(16), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx2), .rx_data(rxd[2]),
    .rx_valid(vld[2]), .frame_err(fe[2]), .parity_err(pe[2]), .busy(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / busy monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        vcnt[i] = vcnt[i] + 1;
        vcyc[i] = cyc;
      end
      if (fe[i]) fcnt[i] = fcnt[i] + 1;
      if (pe[i]) pcnt[i] = pcnt[i] + 1;
      if (bsy[i]) bcnt[i] = bcnt[i] + 1;
      if (int'(vld[i]) + int'(fe[i]) + int'(pe[i]) > 1) multi[i] = multi[i] + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int k, input logic v);
    case (k)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Outcome of one frame: 0 good byte, 1 parity error, 2 frame error.
  function automatic int model(input int mode, input logic [7:0] d, input logic pb, input logic stop);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (!stop) return 2;
    if (mode == 1 && int'(pb) != (ones % 2)) return 1;
    if (mode == 2 && int'(pb) != ((ones + 1) % 2)) return 1;
    return 0;
  endfunction

  // Drives start, 8 data bits, optional parity and stop; rx is left at the stop level.
  task automatic send(input int k, input logic [7:0] d, input int div, input bit par_en,
                      input logic pb, input logic stop, input int chg_bit, input logic [15:0] new_div);
    set_rx(k, 1'b0);
    fall_cyc = cyc;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) baud_div = new_div;
      set_rx(k, d[i]);
      repeat (div) @(negedge clk);
    end
    if (par_en) begin
      set_rx(k, pb);
      repeat (div) @(negedge clk);
    end
    set_rx(k, stop);
    repeat (div) @(negedge clk);
  endtask

  task automatic snap(input int k);
    sv = vcnt[k];
    sf = fcnt[k];
    sp = pcnt[k];
    sb = bcnt[k];
  endtask

  task automatic chk_outcome(input int k, input string tag, input int out, input logic [7:0] d);
    if (out == 0) last_good[k] = d;
    chk({tag, "_valid"}, vcnt[k] - sv, (out == 0) ? 1 : 0);
    chk({tag, "_perr"},  pcnt[k] - sp, (out == 1) ? 1 : 0);
    chk({tag, "_ferr"},  fcnt[k] - sf, (out == 2) ? 1 : 0);
    chk({tag, "_data"},  int'(rxd[k]), int'(last_good[k]));
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_data"},  int'(rxd[i]), 0);
      chk({tag, "_valid"}, int'(vld[i]), 0);
      chk({tag, "_ferr"},  int'(fe[i]), 0);
      chk({tag, "_perr"},  int'(pe[i]), 0);
      chk({tag, "_busy"},  int'(bsy[i]), 0);
    end
  endtask

  initial begin
    int lat, nominal, k, bd, eff, out;
    logic [7:0] d;
    logic pb, stop;

    rst = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    baud_div = 16'd16;
    for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // T1: plain 8N1 byte plus latency window
    baud_div = 16'd16;
    snap(0);
    send(0, 8'hA5, 16, 1'b0, 1'b0, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(0, "t1", 0, 8'hA5);
    lat = vcyc[0] - fall_cyc;
    nominal = 2 + 8 + 9 * 16;
    chk("t1_latency_in_window", (lat >= nominal - 1 && lat <= nominal + 1) ? 1 : 0, 1);

    // T2: glitch shorter than half a bit is a false start
    snap(0);
    set_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    chk("t2_busy_short", (bcnt[0] - sb > 0 && bcnt[0] - sb < 10) ? 1 : 0, 1);
    chk("t2_busy_idle", int'(bsy[0]), 0);
    chk("t2_no_valid", vcnt[0] - sv, 0);
    chk("t2_no_ferr", fcnt[0] - sf, 0);

    // T3: stop bit low, line held in break
    baud_div = 16'd10;
    snap(0);
    send(0, 8'h3C, 10, 1'b0, 1'b0, 1'b0, -1, 16'd0);
    repeat (40) @(negedge clk);
    chk("t3_busy_in_break", int'(bsy[0]), 1);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    chk("t3_busy_after_break", int'(bsy[0]), 0);
    chk_outcome(0, "t3", 2, 8'h3C);

    // T4: even parity, wrong then right parity bit
    baud_div = 16'd8;
    snap(1);
    send(1, 8'h07, 8, 1'b1, 1'b0, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(1, "t4_bad", model(1, 8'h07, 1'b0, 1'b1), 8'h07);
    chk("t4_bad_is_perr", model(1, 8'h07, 1'b0, 1'b1), 1);
    snap(1);
    send(1, 8'h07, 8, 1'b1, 1'b1, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(1, "t4_good", 0, 8'h07);

    // T5: divisor change mid-frame, then the new divisor, then a divisor below 4
    baud_div = 16'd16;
    snap(0);
    send(0, 8'h5A, 16, 1'b0, 1'b0, 1'b1, 3, 16'd32);
    repeat (8) @(negedge clk);
    chk_outcome(0, "t5_old_div", 0, 8'h5A);
    snap(0);
    send(0, 8'hC3, 32, 1'b0, 1'b0, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(0, "t5_new_div", 0, 8'hC3);
    baud_div = 16'd2;
    snap(0);
    send(0, 8'h96, 4, 1'b0, 1'b0, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(0, "t5_min_div", 0, 8'h96);

    // T6: reset in the middle of bit 5 of an all-zero frame
    baud_div = 16'd16;
    snap(0);
    set_rx(0, 1'b0);
    repeat (6 * 16 + 8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_in_reset");
    set_rx(0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
    repeat (200) @(negedge clk);
    chk("t6_abort_no_valid", vcnt[0] - sv, 0);
    chk("t6_abort_no_ferr", fcnt[0] - sf, 0);
    chk("t6_abort_no_perr", pcnt[0] - sp, 0);
    snap(0);
    send(0, 8'h81, 16, 1'b0, 1'b0, 1'b1, -1, 16'd0);
    repeat (8) @(negedge clk);
    chk_outcome(0, "t6_after", 0, 8'h81);

    // Randomised frames across all three parity modes
    for (int n = 0; n < 36; n++) begin
      k = $urandom_range(0, 2);
      d = 8'($urandom);
      bd = $urandom_range(1, 20);
      eff = (bd < 4) ? 4 : bd;
      baud_div = 16'(bd);
      pb = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      out = model(k, d, pb, stop);
      snap(k);
      send(k, d, eff, k != 0, pb, stop, -1, 16'd0);
      if (!stop) begin
        repeat (eff) @(negedge clk);
        set_rx(k, 1'b1);
      end
      repeat (eff + 6) @(negedge clk);
      chk_outcome(k, $sformatf("rand%0d_k%0d", n, k), out, d);
    end

    for (int i = 0; i < 3; i++) chk($sformatf("one_strobe_at_a_time_%0d", i), multi[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
